// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU bus and its UART transmitter peripheral.
package tiny_cpu_pkg;

  typedef enum logic [1:0] {
    CMD_READ    = 2'd0,
    CMD_WRITE   = 2'd1,
    CMD_READ_B  = 2'd2,
    CMD_WRITE_B = 2'd3
  } bus_cmd_t;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

endpackage

// File: rtl/bus_uart_tx_if.sv
// Toggle-handshake bus between the CPU (master) and a bus IP (slave).
interface bus_uart_tx_if;
  logic [15:0] addr;
  logic [1:0]  cmd;
  logic        run;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        done;

  modport master (output addr, cmd, run, wr_data, input rd_data, done);
  modport slave  (input addr, cmd, run, wr_data, output rd_data, done);
endinterface

// File: rtl/bus_uart_tx_byte_fifo.sv
// Synchronous FIFO; dout shows the head entry whenever the FIFO is non-empty.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en, rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus slave with DATA/STATUS registers,
// a transmit FIFO and a serialiser FSM.
module bus_uart_tx
  import tiny_cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_uart_tx_if.slave  bus,
  output logic          txd,
  output logic          tx_busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  uart_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             pop;

  logic       done_q, overflow;
  logic [15:0] rd_q, rd_next, status;
  logic       pending, is_wr, is_status, push, clr_ovf;
  logic [7:0] fifo_dout;
  logic       fifo_full, fifo_empty;
  bus_cmd_t   cmd_e;
  logic       unused_bits;

  assign unused_bits = ^{bus.addr[15:2], bus.wr_data[15:8]};

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(bus.wr_data[7:0]),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  // Bus slave decode
  assign cmd_e     = bus_cmd_t'(bus.cmd);
  assign pending   = (bus.run != done_q);
  assign is_wr     = (cmd_e == CMD_WRITE) || (cmd_e == CMD_WRITE_B);
  assign is_status = (bus.addr[1] == UART_REG_STATUS[1]);
  assign push      = pending && is_wr && !is_status && !((cmd_e == CMD_WRITE_B) && bus.addr[0]);
  assign clr_ovf   = pending && is_wr && is_status;
  assign tx_busy   = (state != UART_IDLE) || !fifo_empty;

  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = tx_busy;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = overflow;
    rd_next            = '0;
    if (is_status) begin
      if (cmd_e == CMD_READ_B) rd_next = bus.addr[0] ? '0 : {8'h00, status[7:0]};
      else                     rd_next = status;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= 1'b0;
      rd_q     <= '0;
      overflow <= 1'b0;
    end else if (pending) begin
      done_q <= ~done_q;
      if (!is_wr) rd_q <= rd_next;
      if (push && fifo_full) overflow <= 1'b1;
      else if (clr_ovf)      overflow <= 1'b0;
    end
  end

  assign bus.done    = done_q;
  assign bus.rd_data = rd_q;

  // Serialiser
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= UART_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    txd     = 1'b1;
    case (state)
      UART_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          cnt_n   = '0;
          state_n = UART_START;
        end
      end
      UART_START: begin
        txd = 1'b0;
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = UART_DATA;
        end else cnt_n = cnt + CNT_W'(1);
      end
      UART_DATA: begin
        txd = shift[0];
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = UART_STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else cnt_n = cnt + CNT_W'(1);
      end
      UART_STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n   = '0;
          state_n = UART_IDLE;
        end else cnt_n = cnt + CNT_W'(1);
      end
      default: state_n = UART_IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register-map table, directed frame /
// overflow / reset sequences, and random traffic against a frame-level model.
module tb_bus_uart_tx;
  import tiny_cpu_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd, tx_busy;

  bus_uart_tx_if bus ();

  bus_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .txd(txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: byte queue plus remaining cycles of the frame on the wire
  logic [7:0]  m_q[$];
  logic [7:0]  m_sent[$];
  int          m_left = 0;
  logic [7:0]  m_cur = '0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_rd = '0;

  // Wire decoder
  logic        rx_act = 1'b0;
  int          rx_s = 0;
  logic [7:0]  rx_b = '0;
  logic [7:0]  rx_q[$];

  typedef struct {
    logic [1:0]  cmd;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[0] = (m_left != 0) || (m_q.size() != 0);
    s[1] = (m_q.size() == DEPTH);
    s[2] = (m_q.size() == 0);
    s[3] = m_ovf;
    return s;
  endfunction

  function automatic logic m_txd();
    logic [9:0] fr;
    int pos;
    if (m_left == 0) return 1'b1;
    fr  = {1'b1, m_cur, 1'b0};
    pos = (FRAME - m_left) / CPB;
    return fr[pos];
  endfunction

  task automatic tick();
    logic full_b, empty_b, pend, wr, push;
    logic [15:0] st;
    if (reset) begin
      m_q.delete();
      m_left = 0; m_ovf = 1'b0; m_done = 1'b0; m_rd = '0;
    end else begin
      st      = m_status();
      full_b  = (m_q.size() == DEPTH);
      empty_b = (m_q.size() == 0);
      pend    = (bus.run != m_done);
      wr      = (bus.cmd == CMD_WRITE) || (bus.cmd == CMD_WRITE_B);
      push    = 1'b0;
      if (pend) begin
        m_done = ~m_done;
        if (wr) begin
          if (bus.addr[1]) m_ovf = 1'b0;
          else if (!(bus.cmd == CMD_WRITE_B && bus.addr[0])) push = 1'b1;
        end else begin
          if (!bus.addr[1])                             m_rd = '0;
          else if (bus.cmd == CMD_READ_B && bus.addr[0]) m_rd = '0;
          else if (bus.cmd == CMD_READ_B)               m_rd = {8'h00, st[7:0]};
          else                                          m_rd = st;
        end
      end
      if (m_left == 0 && !empty_b) begin
        m_cur  = m_q.pop_front();
        m_sent.push_back(m_cur);
        m_left = FRAME;
      end else if (m_left > 0) m_left--;
      if (push) begin
        if (full_b) m_ovf = 1'b1;
        else        m_q.push_back(bus.wr_data[7:0]);
      end
    end
    @(posedge clk);
    #1;
    check("done", 16'(bus.done), 16'(m_done));
    check("txd", 16'(txd), 16'(m_txd()));
    check("tx_busy", 16'(tx_busy), 16'((m_left != 0) || (m_q.size() != 0)));
    check("rd_data", bus.rd_data, m_rd);
    if (reset) rx_act = 1'b0;
    else if (!rx_act) begin
      if (txd == 1'b0) begin rx_act = 1'b1; rx_s = 0; rx_b = '0; end
    end else begin
      rx_s++;
      for (int k = 0; k < 8; k++)
        if (rx_s == CPB * (k + 1) + CPB / 2) rx_b[k] = txd;
      if (rx_s == 9 * CPB + CPB / 2) begin
        check("stop_bit", 16'(txd), 16'h0001);
        rx_q.push_back(rx_b);
        rx_act = 1'b0;
      end
    end
  endtask

  task automatic bus_op(input logic [1:0] c, input logic [1:0] a, input logic [15:0] d);
    bus.cmd     = c;
    bus.addr    = {14'($urandom), a};
    bus.wr_data = d;
    bus.run     = ~bus.run;
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 2000) begin tick(); n++; end
    check("idle_timeout", 16'(tx_busy), 16'h0000);
    repeat (2) tick();
  endtask

  task automatic check_wire(input string name);
    check({name, "_count"}, 16'(rx_q.size()), 16'(m_sent.size()));
    for (int i = 0; i < m_sent.size() && i < rx_q.size(); i++)
      check({name, "_byte"}, 16'(rx_q[i]), 16'(m_sent[i]));
    rx_q.delete();
    m_sent.delete();
  endtask

  initial begin
    logic [9:0] wave;
    tbl[0] = '{CMD_READ,    2'd2, 16'h0000, 16'h0004};
    tbl[1] = '{CMD_READ_B,  2'd3, 16'h0000, 16'h0000};
    tbl[2] = '{CMD_READ_B,  2'd2, 16'h0000, 16'h0004};
    tbl[3] = '{CMD_READ,    2'd0, 16'h0000, 16'h0000};
    tbl[4] = '{CMD_READ,    2'd3, 16'h0000, 16'h0004};
    tbl[5] = '{CMD_READ_B,  2'd1, 16'h0000, 16'h0000};
    tbl[6] = '{CMD_WRITE_B, 2'd1, 16'h0055, 16'h0000};
    tbl[7] = '{CMD_READ,    2'd2, 16'h0000, 16'h0004};
    tbl[8] = '{CMD_WRITE,   2'd2, 16'hFFFF, 16'h0004};
    tbl[9] = '{CMD_READ_B,  2'd0, 16'h0000, 16'h0000};

    bus.run = 1'b0; bus.cmd = '0; bus.addr = '0; bus.wr_data = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("reset_done", 16'(bus.done), 16'h0000);
    check("reset_txd", 16'(txd), 16'h0001);
    check("reset_busy", 16'(tx_busy), 16'h0000);

    // Register map
    for (int i = 0; i < 10; i++) begin
      bus_op(tbl[i].cmd, tbl[i].addr, tbl[i].wdata);
      check($sformatf("table_rd_%0d", i), bus.rd_data, tbl[i].exp_rd);
      repeat (3) tick();
    end
    check_wire("no_frame");

    // Single frame waveform for 0x41
    wave = 10'b1010000010;
    bus_op(CMD_WRITE, 2'd0, 16'h1241);
    check("write_latency", 16'(bus.done), 16'(bus.run));
    tick();
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("wave_%0d", i / CPB), 16'(txd), 16'(wave[i / CPB]));
      tick();
    end
    check("busy_after_stop", 16'(tx_busy), 16'h0000);
    wait_idle();
    check_wire("frame41");

    // Overflow and sticky-bit clear
    for (int b = 1; b <= 5; b++) bus_op(CMD_WRITE, 2'd0, 16'(b));
    bus_op(CMD_READ, 2'd2, 16'h0000);
    check("status_full", bus.rd_data, 16'h0003);
    bus_op(CMD_WRITE, 2'd0, 16'h0006);
    bus_op(CMD_READ, 2'd2, 16'h0000);
    check("status_ovf", bus.rd_data, 16'h000B);
    bus_op(CMD_WRITE, 2'd2, 16'h1234);
    bus_op(CMD_READ, 2'd2, 16'h0000);
    check("status_ovf_clr", bus.rd_data, 16'h0003);
    wait_idle();
    check("ovf_wire_count", 16'(rx_q.size()), 16'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check("ovf_wire_byte", 16'(rx_q[i]), 16'(i + 1));
    check_wire("ovf");

    // Reset during data bit 3 with a request held pending across release
    bus_op(CMD_WRITE, 2'd0, 16'h005A);
    bus_op(CMD_WRITE, 2'd0, 16'h0011);
    bus_op(CMD_WRITE, 2'd0, 16'h0022);
    repeat (16) tick();
    reset = 1'b1;
    bus.cmd = CMD_READ; bus.addr = 16'h0002; bus.run = 1'b1;
    tick();
    check("rst_mid_txd", 16'(txd), 16'h0001);
    check("rst_mid_busy", 16'(tx_busy), 16'h0000);
    check("rst_mid_done", 16'(bus.done), 16'h0000);
    reset = 1'b0;
    tick();
    check("rst_release_done", 16'(bus.done), 16'h0001);
    check("rst_release_status", bus.rd_data, 16'h0004);
    repeat (4) tick();
    rx_q.delete();
    m_sent.delete();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [1:0] c, a;
      c = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus_op(c, a, 16'($urandom));
      repeat ($urandom_range(0, 20)) tick();
    end
    wait_idle();
    check_wire("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
Memory-mapped UART transmitter that attaches to the CPU's toggle-handshake bus as a second bus IP, alongside the memory. The CPU writes bytes into a small transmit FIFO through a DATA register and polls a STATUS register. Bytes are serialised 8N1 onto a single TX pin. This is the first peripheral downstream of the CPU bus master that is not memory.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit (>=2)
FIFO_DEPTH, 4, transmit FIFO entries, power of two (>=2)

Ports:
clk  input  1  sole clock; all logic on posedge
reset  input  1  synchronous, active-high
addr  input  16  bus address; only addr[1:0] decoded (chip select is external)
cmd  input  2  bus command: read=0, write=1, read_b=2, write_b=3
run  input  1  request toggle from master
wr_data  input  16  write data
rd_data  output  16  read data, valid when done == run
done  output  1  completion toggle
txd  output  1  serial out, idle high
tx_busy  output  1  high while FIFO non-empty or a frame is in flight

Behaviour:
- Reset values: done=0, rd_data=0, txd=1, tx_busy=0, FIFO empty, overflow=0, serialiser IDLE. Reset mid-frame aborts the frame; txd is 1 on the cycle after reset is sampled.
- Handshake: a request is pending when run != done. It is serviced on the first posedge where it is pending and reset is low. done toggles at that same edge, so latency is 1 cycle. rd_data updates at that edge and holds until the next read. One request is serviced per toggle; the master must not toggle run again until done == run. A request pending at reset release is serviced normally.
- Register map, addr[1]: 0 = DATA, 1 = STATUS.
  - STATUS bits: [0] tx_busy, [1] fifo_full, [2] fifo_empty, [3] overflow (sticky). Bits [15:4] = 0.
- Writes:
  - write or write_b to addr[1:0]=00 pushes wr_data[7:0] into the FIFO.
  - write_b to addr[1:0]=01 is ignored; done still toggles.
  - Any write to STATUS clears overflow.
- Reads:
  - DATA reads return 0.
  - read of STATUS returns the 16-bit word.
  - read_b of STATUS returns {8'h00, status[7:0]} at addr[0]=0, and 16'h0000 at addr[0]=1.
  - Read values reflect state before any same-cycle pop.
- FIFO full rule: fullness is evaluated before any same-cycle pop. A push while full is dropped and sets overflow. A push and a pop in the same cycle when not full leaves the count unchanged.
- Serialiser FSM:
  - IDLE: txd=1. If FIFO non-empty, pop the head into the shift register and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shift right after each bit; after bit 7 go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
  - A frame is 10*CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly one IDLE cycle with txd=1.
- Counters: the bit-cycle counter is $clog2(CLKS_PER_BIT) bits and resets to 0 on each state or bit change. The FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is one bit wider.
- tx_busy = (state != IDLE) || !fifo_empty, registered-consistent with STATUS[0].

Decomposition:
- Shared package tiny_cpu_pkg holds:
  - bus_cmd_t enum (read/write/read_b/write_b), replacing the loose bus_cmd constants
  - UART register offsets (DATA=0, STATUS=2)
  - STATUS bit-position constants
  - uart_state_t enum (IDLE/START/DATA/STOP)
- Sub-module byte_fifo: a synchronous FIFO with params DEPTH and WIDTH=8, ports push/pop/din/dout/full/empty, and first-word dout valid while not empty.
- The serialiser FSM and the bus slave stay in bus_uart_tx.

Test Plan:
- Reset with run=0 -> done=0, txd=1, tx_busy=0; STATUS read returns 16'h0004.
- write 16'h1241 to addr 0 -> done toggles 1 cycle later. txd shows 0,1,0,0,0,0,0,1,0,1, each for 4 cycles (40 cycles total). tx_busy falls after the stop bit.
- Five writes of 0x01..0x05 while the serialiser is stalled in the first frame -> 0x01 is in flight and 0x02..0x05 fill the FIFO. STATUS read gives bit1=1 and bit3=0. A sixth write of 0x06 sets bit3. The wire shows 01..05 only, never 06.
- Write STATUS with any data after an overflow -> bit3 clears; FIFO contents are unaffected.
- read_b of STATUS at addr 3 -> 16'h0000. write_b 0x55 to addr 1 -> no frame emitted; done still toggles.
- Assert reset mid-DATA bit 3 -> txd=1 next cycle, FIFO empty, done=0. With run=1 held, one request is serviced right after reset release.
